mul: RTL and testbench

MUL -- requirements
Module: mul

---
 rtl/mul_pkg.sv | 14 +
 rtl/sum.sv | 16 +
 rtl/mul.sv | 87 ++++++++
 tb/tb_mul.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared widths, iteration count and FSM state type for the shift-and-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;
  localparam int OP_W   = 8;               // operand width
  localparam int PROD_W = 16;              // product width
  localparam int ITERS  = 8;               // one WORK cycle per multiplier bit
  localparam int CNT_W  = $clog2(ITERS);   // iteration counter width

  typedef enum logic {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_e;
endpackage

// File: rtl/sum.sv
// Purely combinational 16-bit adder used by mul for every addition.
// Latency: combinational, zero cycles.
// Backpressure: none; result follows inputs continuously.
// Ports: a, b - addends; result - (a + b) mod 2^16.
module sum
  import mul_pkg::*;
(
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  output logic [PROD_W-1:0] result
);

  // Carry out of the top bit is dropped, giving modulo-2^16 wrap.
  assign result = a + b;

endmodule

// File: rtl/mul.sv
// 8x8 unsigned shift-and-add multiplier; all additions go through an external adder.
// Latency: busy high for exactly 8 cycles after the start edge; result valid as busy falls.
// Backpressure: start is accepted only when idle; start while busy is dropped, not queued.
// Ports: clk/rst (sync, active-high); a_i/b_i/start request; result/busy status;
//        sum_in_a/sum_in_b drive the external adder, sum_out is its combinational result.
module mul
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  input  logic              start,
  output logic [PROD_W-1:0] result,
  output logic              busy,
  output logic [PROD_W-1:0] sum_in_a,
  output logic [PROD_W-1:0] sum_in_b,
  input  logic [PROD_W-1:0] sum_out
);

  state_e              state_q,  state_d;
  logic [PROD_W-1:0]   mcand_q,  mcand_d;   // multiplicand, shifted left each step
  logic [OP_W-1:0]     mplier_q, mplier_d;  // multiplier, shifted right each step
  logic [PROD_W-1:0]   acc_q,    acc_d;     // running partial product
  logic [CNT_W-1:0]    cnt_q,    cnt_d;     // completed WORK steps
  logic [PROD_W-1:0]   result_q, result_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sum_in_a = '0;
    sum_in_b = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WORK;
          mcand_d  = {{(PROD_W-OP_W){1'b0}}, a_i};
          mplier_d = b_i;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      WORK: begin
        // Add the shifted multiplicand only when the current multiplier bit is set.
        sum_in_a = acc_q;
        sum_in_b = mplier_q[0] ? mcand_q : '0;
        acc_d    = sum_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          // Final step: the adder output is already the full product.
          result_d = sum_out;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy   = (state_q == WORK);
  assign result = result_q;

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul wired to an external sum adder, plus a standalone adder check.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_mul;
  import mul_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [OP_W-1:0]   a_i = '0;
  logic [OP_W-1:0]   b_i = '0;
  logic              start = 1'b0;
  logic [PROD_W-1:0] result;
  logic              busy;
  logic [PROD_W-1:0] sum_in_a, sum_in_b, sum_out;

  logic [PROD_W-1:0] chk_a = '0, chk_b = '0, chk_r;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mul u_mul (
    .clk      (clk),
    .rst      (rst),
    .a_i      (a_i),
    .b_i      (b_i),
    .start    (start),
    .result   (result),
    .busy     (busy),
    .sum_in_a (sum_in_a),
    .sum_in_b (sum_in_b),
    .sum_out  (sum_out)
  );

  sum u_sum (
    .a      (sum_in_a),
    .b      (sum_in_b),
    .result (sum_out)
  );

  sum u_sum_chk (
    .a      (chk_a),
    .b      (chk_b),
    .result (chk_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Caller must be at a negedge with the DUT idle; returns at the negedge where busy
  // is first seen low, i.e. the first idle cycle, so consecutive calls are back-to-back.
  // intr_at/rst_at: WORK cycle (1..8) at which to pulse a stray start / reset; 0 = never.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input int intr_at, input int rst_at);
    logic [PROD_W-1:0] prev;
    int  cyc;
    bit  done;
    int  exp_cyc;
    int  exp_res;
    prev  = result;
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    cyc   = 0;
    done  = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      if (!busy) begin
        done = 1'b1;
      end else begin
        cyc++;
        check("hold_during_work", result, prev);
        // Operand changes mid-operation must not matter.
        a_i = OP_W'($urandom);
        b_i = OP_W'($urandom);
        if (cyc == intr_at) begin
          start = 1'b1;
          a_i   = 8'd2;
          b_i   = 8'd2;
        end
        if (cyc == rst_at) rst = 1'b1;
      end
    end
    if (!done) check("busy_timeout", 32'd1, 32'd0);
    exp_cyc = (rst_at != 0) ? rst_at : ITERS;
    exp_res = (rst_at != 0) ? 0 : int'(a) * int'(b);
    check("busy_cycles", cyc, exp_cyc);
    check("result", result, exp_res);
    check("idle_sum_in_a", sum_in_a, 0);
    check("idle_sum_in_b", sum_in_b, 0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_sum_in_a", sum_in_a, 0);
    check("rst_sum_in_b", sum_in_b, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Standalone adder: wrap and a plain sum.
    chk_a = 16'hFFFF; chk_b = 16'h0001; #1;
    check("sum_wrap", chk_r, 16'h0000);
    chk_a = 16'h1234; chk_b = 16'h0F0F; #1;
    check("sum_plain", chk_r, 16'h2143);

    // Directed operations, back-to-back.
    do_op(8'd3,   8'd2,   0, 0);
    do_op(8'd5,   8'd5,   0, 0);
    do_op(8'd4,   8'd3,   0, 0);
    do_op(8'd255, 8'd255, 0, 0);
    do_op(8'd255, 8'd0,   0, 0);
    do_op(8'd0,   8'd77,  0, 0);
    // Stray start during WORK is ignored.
    do_op(8'd7,   8'd9,   3, 0);
    // Reset mid-operation aborts it; then a fresh operation works.
    do_op(8'd200, 8'd100, 0, 4);
    do_op(8'd6,   8'd7,   0, 0);

    // Randomised operations checked against a*b.
    for (int i = 0; i < 40; i++) begin
      do_op(8'($urandom), 8'($urandom), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
